// File: rtl/noc_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_mul_pkg
// Purpose  : Shared constants, state encoding and index helper for the
//            shared multiplier-cell scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package noc_mul_pkg;

    localparam int CELL_DW = 32;   // operand/result width of the cell path
    localparam int HW      = 16;   // half-width used by the 16x16 cell
    localparam int MAX_REQ = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_CAPT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Circular index (base + off) mod n, with base < n and off < n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage : noc_mul_pkg
`default_nettype wire

// File: rtl/noc_mul_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : noc_mul_rr_arb
// Purpose  : Combinational round-robin pick of the first request at or after
//            the priority pointer; returns one-hot grant and its index.
// Revision : 1.0 - initial release
// ============================================================================
module noc_mul_rr_arb
    import noc_mul_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_gnt
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!any_gnt && req[wrap_idx(int'(ptr), off, NUM_REQ)]) begin
                any_gnt = 1'b1;
                gnt[wrap_idx(int'(ptr), off, NUM_REQ)] = 1'b1;
                gnt_idx = IDX_W'(wrap_idx(int'(ptr), off, NUM_REQ));
            end
        end
    end

endmodule : noc_mul_rr_arb
`default_nettype wire

// File: rtl/noc_mul_cell_sched.sv
`default_nettype none
// ============================================================================
// Module   : noc_mul_cell_sched
// Purpose  : Shares a three-partial-product 16x16 multiplier cell among
//            NUM_REQ requesters and returns the low 32 bits of A*B.
// Revision : 1.0 - initial release
// ============================================================================
module noc_mul_cell_sched
    import noc_mul_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [DW-1:0]         rsp_data,
    output logic                  busy,
    output logic [DW-1:0]         cell_src1,
    output logic [DW-1:0]         cell_src2,
    output logic                  cell_en,
    input  logic [31:0]           cell_p1,
    input  logic [31:0]           cell_p2,
    input  logic [31:0]           cell_p3
);

    localparam int IW = $clog2(NUM_REQ);

    logic [1:0]         r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_gidx;
    logic [DW-1:0]      r_a;
    logic [DW-1:0]      r_b;
    logic [DW-1:0]      r_rsp;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gidx;
    logic               w_any;
    logic               w_accept;
    logic [DW-1:0]      w_sel_a;
    logic [DW-1:0]      w_sel_b;
    logic [NUM_REQ-1:0] w_rsp_onehot;
    logic               w_rsp_done;
    logic [IW-1:0]      w_ptr_next;
    logic [HW-1:0]      w_cross;
    logic [DW-1:0]      w_product;
    logic               w_unused_hi;

    noc_mul_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gidx),
        .any_gnt (w_any)
    );

    // Grant depends only on state and req_valid, never on req_ready itself.
    assign w_accept  = (r_state == ST_IDLE) && w_any && !reset;
    assign req_ready = w_accept ? w_gnt : '0;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_a[i*DW +: DW];
                w_sel_b = req_b[i*DW +: DW];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_sel
            assign w_rsp_onehot[gi] = (r_gidx == IW'(gi));
        end
    endgenerate

    assign rsp_valid  = (r_state == ST_RESP) ? w_rsp_onehot : '0;
    assign w_rsp_done = (r_state == ST_RESP) && |(rsp_ready & w_rsp_onehot);
    assign w_ptr_next = (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

    // Only the low half of the cross products lands inside the 32-bit result.
    assign w_cross     = cell_p2[HW-1:0] + cell_p3[HW-1:0];
    assign w_product   = cell_p1 + {w_cross, {HW{1'b0}}};
    assign w_unused_hi = ^{cell_p2[31:HW], cell_p3[31:HW]};

    assign cell_src1 = r_a;
    assign cell_src2 = r_b;
    assign cell_en   = (r_state == ST_ISSUE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_data  = r_rsp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rsp   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_gidx  <= w_gidx;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: r_state <= ST_CAPT;
                ST_CAPT: begin
                    r_rsp   <= w_product;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : noc_mul_cell_sched
`default_nettype wire

// File: tb/tb_noc_mul_cell_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_mul_cell_sched
// Purpose  : Self-checking bench with a cell model and response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_mul_cell_sched;

    localparam int NUM_REQ = 2;
    localparam int DW      = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [DW-1:0]         rsp_data;
    logic                  busy;
    logic [DW-1:0]         cell_src1;
    logic [DW-1:0]         cell_src2;
    logic                  cell_en;
    logic [31:0]           cell_p1 = '0;
    logic [31:0]           cell_p2 = '0;
    logic [31:0]           cell_p3 = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rsp    = 0;
    int cyc      = 0;
    int model_ptr = 0;

    typedef struct packed {
        int          idx;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    noc_mul_cell_sched #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier cell: one register stage gated by its enable.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
    end

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            model_ptr = 0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.idx = i;
                    mon_e.exp = req_a[i*DW +: DW] * req_b[i*DW +: DW];
                    sb_q.push_back(mon_e);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    n_checks++;
                    n_rsp++;
                    model_ptr = (i + 1) % NUM_REQ;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: response on %0d data %h, required no response", i, rsp_data);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (mon_e.idx != i || rsp_data !== mon_e.exp) begin
                            n_fail++;
                            $display("FAIL sb_result: got req %0d data %h, required req %0d data %h",
                                     i, rsp_data, mon_e.idx, mon_e.exp);
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] b, output int t_acc);
        bit ok;
        ok = 1'b0;
        t_acc = -1;
        req_a[idx*DW +: DW] = a;
        req_b[idx*DW +: DW] = b;
        req_valid[idx] = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                ok = 1'b1;
                t_acc = cyc;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req %0d not accepted, required accept", idx);
        end
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int idx, output logic [31:0] data);
        bit ok;
        ok = 1'b0;
        data = 'x;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rsp_valid[idx] && rsp_ready[idx]) begin
                ok = 1'b1;
                data = rsp_data;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: req %0d no response, required response", idx);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && req_valid == '0) break;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: busy %b, required 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, busy, cell_en, cell_src1, cell_src2} !== '0) begin
            n_fail++;
            $display("FAIL reset_in: rdy %b vld %b data %h busy %b en %b s1 %h s2 %h, required all 0",
                     req_ready, rsp_valid, rsp_data, busy, cell_en, cell_src1, cell_src2);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, busy, cell_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: rdy %b vld %b data %h busy %b en %b, required all 0",
                     req_ready, rsp_valid, rsp_data, busy, cell_en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int t_acc;
        int en_cnt;
        int en_cyc;
        int first;
        logic [31:0] data;
        en_cnt = 0;
        en_cyc = -1;
        first  = -1;
        data   = '0;
        rsp_ready = '1;
        issue(0, 32'h0003_0002, 32'h0005_0004, t_acc);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cell_en) begin
                en_cnt++;
                en_cyc = cyc;
            end
            if (rsp_valid[0] && first < 0) begin
                first = cyc;
                data  = rsp_data;
            end
        end
        n_checks++;
        if (first - t_acc != 3) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, required 3", first - t_acc);
        end
        n_checks++;
        if (en_cnt != 1 || en_cyc != t_acc + 1) begin
            n_fail++;
            $display("FAIL single_cell_en: %0d pulses at offset %0d, required 1 at offset 1",
                     en_cnt, en_cyc - t_acc);
        end
        n_checks++;
        if (data !== 32'h0016_0008) begin
            n_fail++;
            $display("FAIL single_data: got %h, required 00160008", data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        int t_acc;
        logic [31:0] data;
        rsp_ready = '1;
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t_acc);
        wait_rsp(0, data);
        n_checks++;
        if (data !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL wrap_ones: got %h, required 00000001", data);
        end
        issue(1, 32'h0001_0000, 32'h0001_0000, t_acc);
        wait_rsp(1, data);
        n_checks++;
        if (data !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_hi: got %h, required 00000000", data);
        end
    endtask

    task automatic test_contention();
        int got;
        int prev_g;
        int prev_c;
        int acc;
        int exp_g;
        got = 0;
        prev_g = -1;
        prev_c = 0;
        rsp_ready = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*DW +: DW] = $urandom();
            req_b[i*DW +: DW] = $urandom();
        end
        req_valid = '1;
        for (int c = 0; c < 200 && got < 8; c++) begin
            @(negedge clk);
            acc = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) acc = i;
            end
            if (acc >= 0) begin
                exp_g = model_ptr;
                n_checks++;
                if (acc != exp_g) begin
                    n_fail++;
                    $display("FAIL cont_grant: got %0d, required %0d", acc, exp_g);
                end
                if (got > 0) begin
                    n_checks++;
                    if (cyc - prev_c != 4 || acc == prev_g) begin
                        n_fail++;
                        $display("FAIL cont_interval: got %0d cycles grant %0d after %0d, required 4 alternating",
                                 cyc - prev_c, acc, prev_g);
                    end
                end
                prev_c = cyc;
                prev_g = acc;
                got++;
                @(posedge clk);
                #1;
                req_a[acc*DW +: DW] = $urandom();
                req_b[acc*DW +: DW] = $urandom();
            end
        end
        n_checks++;
        if (got != 8) begin
            n_fail++;
            $display("FAIL cont_count: got %0d accepts, required 8", got);
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_backpressure();
        int t_acc;
        bit bad_v;
        bit bad_d;
        bit bad_r;
        bit bad_b;
        logic [31:0] held;
        logic [31:0] exp;
        bad_v = 0;
        bad_d = 0;
        bad_r = 0;
        bad_b = 0;
        held = '0;
        exp = 32'h1234_5678 * 32'h9ABC_DEF1;
        rsp_ready = 2'b10;
        issue(0, 32'h1234_5678, 32'h9ABC_DEF1, t_acc);
        req_a[DW +: DW] = 32'h0000_0007;
        req_b[DW +: DW] = 32'h0000_0009;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[0]) break;
        end
        held = rsp_data;
        n_checks++;
        if (held !== exp) begin
            n_fail++;
            $display("FAIL bp_data: got %h, required %h", held, exp);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b01) bad_v = 1;
            if (rsp_data !== held) bad_d = 1;
            if (req_ready !== '0) bad_r = 1;
            if (busy !== 1'b1) bad_b = 1;
        end
        n_checks++;
        if (bad_v || bad_d) begin
            n_fail++;
            $display("FAIL bp_hold: valid unstable %b data unstable %b, required stable", bad_v, bad_d);
        end
        n_checks++;
        if (bad_r || bad_b) begin
            n_fail++;
            $display("FAIL bp_block: ready seen %b busy dropped %b, required ready 0 busy 1", bad_r, bad_b);
        end
        @(posedge clk);
        #1;
        rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: busy %b ready %b, required busy 0 ready 10", busy, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        int t_acc;
        logic [31:0] data;
        for (int s = 0; s < 3; s++) begin
            rsp_ready = '1;
            issue(0, 32'd3, 32'd5, t_acc);
            wait_rsp(0, data);
            rsp_ready = '0;
            issue(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, t_acc);
            repeat (s) @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({req_ready, rsp_valid, rsp_data, busy, cell_en, cell_src1, cell_src2} !== '0) begin
                n_fail++;
                $display("FAIL rstmid_%0d: rdy %b vld %b data %h busy %b en %b s1 %h s2 %h, required all 0",
                         s, req_ready, rsp_valid, rsp_data, busy, cell_en, cell_src1, cell_src2);
            end
            @(posedge clk);
            #1;
            rsp_ready = '1;
            req_a[0 +: DW]  = 32'h0000_0011;
            req_b[0 +: DW]  = 32'h0000_0013;
            req_a[DW +: DW] = 32'h0102_0304 + s;
            req_b[DW +: DW] = 32'h0A0B_0C0D;
            req_valid = '1;
            @(negedge clk);
            n_checks++;
            if (req_ready !== 2'b01) begin
                n_fail++;
                $display("FAIL rstmid_ptr_%0d: ready %b, required 01", s, req_ready);
            end
            @(posedge clk);
            #1;
            req_valid[0] = 1'b0;
            wait_rsp(1, data);
            req_valid = '0;
            n_checks++;
            if (data !== (32'h0102_0304 + s) * 32'h0A0B_0C0D) begin
                n_fail++;
                $display("FAIL rstmid_op_%0d: got %h, required %h", s, data,
                         (32'h0102_0304 + s) * 32'h0A0B_0C0D);
            end
            drain();
        end
    endtask

    task automatic test_random();
        int raised;
        int accepted;
        int rsp0;
        bit done;
        logic [NUM_REQ-1:0] acc_mask;
        raised = 0;
        accepted = 0;
        done = 0;
        rsp0 = n_rsp;
        for (int c = 0; c < 40000; c++) begin
            @(negedge clk);
            acc_mask = req_valid & req_ready;
            for (int i = 0; i < NUM_REQ; i++) if (acc_mask[i]) accepted++;
            if (raised == 1000 && req_valid == '0 && !busy && sb_q.size() == 0) begin
                done = 1;
                break;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_mask[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && raised < 1000 && $urandom_range(0, 1) == 1) begin
                    req_a[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
                    req_b[i*DW +: DW] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_0000 : $urandom();
                    req_valid[i] = 1'b1;
                    raised++;
                end
            end
            rsp_ready = NUM_REQ'($urandom());
        end
        rsp_ready = '1;
        n_checks++;
        if (!done || accepted != 1000 || n_rsp - rsp0 != 1000) begin
            n_fail++;
            $display("FAIL random_count: done %0d accepted %0d responses %0d, required 1000/1000",
                     done, accepted, n_rsp - rsp0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d pending, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_noc_mul_cell_sched
`default_nettype wire
